ls669_chain_ctrl: RTL

Sequencer for a cascade of `sn74ls669` 4-bit synchronous up/down counters used as address/scroll counters. It accepts a command with a start value, step count and direction, and drives the chain's load, direction and enable pins in the order the LS669 requires: direction changes only while both enables are inactive. It counts the requested number of steps, honours pause requests, and reports completion, terminal-count wrap and shadow-count mismatches. It sits between a CPU/timing-generator command source and the counter chain.

---
 rtl/ls669_ctrl_pkg.sv | 14 +
 rtl/ls669_shadow_cnt.sv | 37 +++
 rtl/sn74ls669.sv | 32 +++
 rtl/ls669_chain_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ls669_ctrl_pkg.sv
// rtl/ls669_ctrl_pkg.sv - shared state and direction encodings for the LS669 chain controller
package ls669_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETDIR = 2'd1,
        ST_LOAD   = 2'd2,
        ST_COUNT  = 2'd3
    } state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/ls669_shadow_cnt.sv
// rtl/ls669_shadow_cnt.sv - shadow up/down counter holding the value the chain should show
module ls669_shadow_cnt
    import ls669_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] start,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = start;
        end else if (en) begin
            count_d = (up == DIR_DN) ? count_q - W'(1) : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sn74ls669.sv
// rtl/sn74ls669.sv - behavioural model of one 4-bit synchronous up/down counter stage
module sn74ls669 (
    input  logic       CLK,
    input  logic       LOADn,
    input  logic       U_Dn,
    input  logic       ENPn,
    input  logic       ENTn,
    input  logic [3:0] D,
    output logic [3:0] Q,
    output logic       RCOn
);

    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (!LOADn) begin
            q_d = D;
        end else if (!ENPn && !ENTn) begin
            q_d = U_Dn ? q_q + 4'd1 : q_q - 4'd1;
        end
    end

    // No reset: the physical part keeps its count across controller resets.
    always_ff @(posedge CLK) begin
        q_q <= q_d;
    end

    assign Q    = q_q;
    assign RCOn = !(!ENTn && (U_Dn ? (q_q == 4'hF) : (q_q == 4'h0)));

endmodule

// File: rtl/ls669_chain_ctrl.sv
// rtl/ls669_chain_ctrl.sv - command sequencer for a cascade of LS669 up/down counters
module ls669_chain_ctrl
    import ls669_ctrl_pkg::*;
#(
    parameter  int STAGES = 2,
    localparam int W      = 4 * STAGES
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         CMD_VALID,
    output logic         CMD_READY,
    input  logic [W-1:0] CMD_START,
    input  logic [W-1:0] CMD_LEN,
    input  logic         CMD_DIR,
    input  logic         HOLD,
    output logic         LOADn,
    output logic         U_Dn,
    output logic         ENABLE_Pn,
    output logic         ENABLE_Tn,
    output logic [W-1:0] DATA,
    input  logic [W-1:0] Q,
    input  logic         RCOn,
    output logic         BUSY,
    output logic         DONE,
    output logic         WRAP,
    output logic         MISMATCH
);

    state_e       state_q, state_d;
    logic         loadn_q, loadn_d;
    logic         ud_q, ud_d;
    logic         enp_q, enp_d;
    logic         ent_q, ent_d;
    logic [W-1:0] data_q, data_d;
    logic [W-1:0] start_q, start_d;
    logic [W-1:0] rem_q, rem_d;
    logic         ready_q, ready_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         wrap_q, wrap_d;
    logic         mism_q, mism_d;
    logic [W-1:0] shadow;
    logic         shadow_load;
    logic         shadow_en;

    // The shadow steps on exactly the edges where the chain itself counts.
    assign shadow_load = (state_q == ST_LOAD);
    assign shadow_en   = (state_q == ST_COUNT) && !enp_q;

    ls669_shadow_cnt #(.W(W)) u_shadow (
        .clk   (CLOCK),
        .rst   (RESET),
        .load  (shadow_load),
        .en    (shadow_en),
        .up    (ud_q),
        .start (start_q),
        .count (shadow)
    );

    always_comb begin
        state_d = state_q;
        loadn_d = 1'b1;
        enp_d   = 1'b1;
        ent_d   = 1'b1;
        ud_d    = ud_q;
        data_d  = data_q;
        start_d = start_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        wrap_d  = wrap_q;
        mism_d  = mism_q;

        if ((state_q == ST_COUNT || done_q) && Q != shadow) begin
            mism_d = 1'b1;
        end
        if (state_q == ST_COUNT && !enp_q && !ent_q && !RCOn) begin
            wrap_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    start_d = CMD_START;
                    rem_d   = CMD_LEN;
                    ud_d    = CMD_DIR;
                    wrap_d  = 1'b0;
                    mism_d  = 1'b0;
                    state_d = ST_SETDIR;
                end
            end
            ST_SETDIR: begin
                loadn_d = 1'b0;
                data_d  = start_q;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ent_d   = 1'b0;
                    enp_d   = HOLD;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                ent_d = 1'b0;
                enp_d = HOLD;
                if (!enp_q) begin
                    rem_d = rem_q - W'(1);
                    if (rem_q == W'(1)) begin
                        ent_d   = 1'b1;
                        enp_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = !ready_d;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            loadn_q <= 1'b1;
            ud_q    <= DIR_UP;
            enp_q   <= 1'b1;
            ent_q   <= 1'b1;
            data_q  <= '0;
            start_q <= '0;
            rem_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            loadn_q <= loadn_d;
            ud_q    <= ud_d;
            enp_q   <= enp_d;
            ent_q   <= ent_d;
            data_q  <= data_d;
            start_q <= start_d;
            rem_q   <= rem_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            mism_q  <= mism_d;
        end
    end

    assign CMD_READY = ready_q;
    assign LOADn     = loadn_q;
    assign U_Dn      = ud_q;
    assign ENABLE_Pn = enp_q;
    assign ENABLE_Tn = ent_q;
    assign DATA      = data_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign WRAP      = wrap_q;
    assign MISMATCH  = mism_q;

endmodule
